// File: rtl/decode_wb_seq.sv
// SEQ Y86-64 decode and write-back: register file, operand reads,
// edge commit of val_e/val_m, sticky status and retired counter.
module decode_wb_seq #(
  parameter int         CNT_W  = 32,
  parameter logic [3:0] RSP_ID = 4'd4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       in_code,
  input  logic [3:0]       in_fun,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic             flag_halt,
  input  logic             bad_mem,
  input  logic             in_error,
  input  logic             dmem_error,
  input  logic             cnd,
  input  logic [63:0]      val_e,
  input  logic [63:0]      val_m,
  input  logic [3:0]       dbg_sel,
  output logic [63:0]      val_a,
  output logic [63:0]      val_b,
  output logic [3:0]       dst_e,
  output logic [3:0]       dst_m,
  output logic [1:0]       stat,
  output logic [CNT_W-1:0] retired,
  output logic [63:0]      dbg_val
);

  localparam logic [3:0] NONE = 4'hF;
  localparam logic [1:0] AOK  = 2'd0;
  localparam logic [1:0] HLT  = 2'd1;
  localparam logic [1:0] ADR  = 2'd2;
  localparam logic [1:0] INS  = 2'd3;

  logic [63:0]      r_rf [15];
  logic [1:0]       r_stat;
  logic [1:0]       w_stat_nxt;
  logic [CNT_W-1:0] r_ret;
  logic [3:0]       w_src_a;
  logic [3:0]       w_src_b;
  logic [3:0]       w_dst_e;
  logic [3:0]       w_dst_m;
  logic             w_commit;
  logic             w_unused_fun;

  assign w_unused_fun = ^in_fun;

  always_comb begin
    w_src_a = NONE;
    w_src_b = NONE;
    w_dst_e = NONE;
    w_dst_m = NONE;
    case (in_code)
      4'h2: begin
        w_src_a = ra;
        w_dst_e = cnd ? rb : NONE;
      end
      4'h3: w_dst_e = rb;
      4'h4: begin
        w_src_a = ra;
        w_src_b = rb;
      end
      4'h5: begin
        w_src_b = rb;
        w_dst_m = ra;
      end
      4'h6: begin
        w_src_a = ra;
        w_src_b = rb;
        w_dst_e = rb;
      end
      4'h8: begin
        w_src_b = RSP_ID;
        w_dst_e = RSP_ID;
      end
      4'h9: begin
        w_src_a = RSP_ID;
        w_src_b = RSP_ID;
        w_dst_e = RSP_ID;
      end
      4'hA: begin
        w_src_a = ra;
        w_src_b = RSP_ID;
        w_dst_e = RSP_ID;
      end
      4'hB: begin
        w_src_a = RSP_ID;
        w_src_b = RSP_ID;
        w_dst_e = RSP_ID;
        w_dst_m = ra;
      end
      default: ;
    endcase
  end

  function automatic logic [63:0] rd(input logic [3:0] id);
    rd = (id == NONE) ? 64'd0 : r_rf[id];
  endfunction

  assign val_a   = rd(w_src_a);
  assign val_b   = rd(w_src_b);
  assign dbg_val = rd(dbg_sel);
  assign dst_e   = w_dst_e;
  assign dst_m   = w_dst_m;

  assign w_commit = (r_stat == AOK) && !flag_halt && !bad_mem
                    && !in_error && !dmem_error;

  // Status: address faults outrank bad instructions, which outrank halt.
  always_comb begin
    w_stat_nxt = r_stat;
    if (r_stat == AOK) begin
      if (bad_mem || dmem_error) w_stat_nxt = ADR;
      else if (in_error)         w_stat_nxt = INS;
      else if (flag_halt)        w_stat_nxt = HLT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_stat <= AOK;
    else       r_stat <= w_stat_nxt;
  end

  // M-port checked first so popq %rsp keeps the loaded value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) r_rf[i] <= 64'd0;
    end else if (w_commit) begin
      for (int i = 0; i < 15; i++) begin
        if (w_dst_m == 4'(i))      r_rf[i] <= val_m;
        else if (w_dst_e == 4'(i)) r_rf[i] <= val_e;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                        r_ret <= '0;
    else if (w_commit && r_ret != '1) r_ret <= r_ret + 1'b1;
  end

  assign stat    = r_stat;
  assign retired = r_ret;

endmodule

// File: tb/tb_decode_wb_seq.sv
// Bench for decode_wb_seq: spec-level model compared every cycle,
// plus directed literal checks on the test-plan scenarios.
module tb_decode_wb_seq;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    in_code, in_fun, ra, rb, dbg_sel;
  logic          flag_halt, bad_mem, in_error, dmem_error, cnd;
  logic [63:0]   val_e, val_m;
  logic [63:0]   val_a, val_b, dbg_val;
  logic [3:0]    dst_e, dst_m;
  logic [1:0]    stat;
  logic [CW-1:0] retired;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [63:0]   m_regs [15];
  logic [1:0]    m_stat;
  logic [CW-1:0] m_ret;

  decode_wb_seq #(.CNT_W(CW), .RSP_ID(4'd4)) dut (
    .clock(clock), .reset(reset), .in_code(in_code), .in_fun(in_fun),
    .ra(ra), .rb(rb), .flag_halt(flag_halt), .bad_mem(bad_mem),
    .in_error(in_error), .dmem_error(dmem_error), .cnd(cnd),
    .val_e(val_e), .val_m(val_m), .dbg_sel(dbg_sel),
    .val_a(val_a), .val_b(val_b), .dst_e(dst_e), .dst_m(dst_m),
    .stat(stat), .retired(retired), .dbg_val(dbg_val)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] f_src_a();
    if (in_code inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (in_code inside {4'h9, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] f_src_b();
    if (in_code inside {4'h4, 4'h5, 4'h6}) return rb;
    if (in_code inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] f_dst_e();
    if (in_code == 4'h2) return cnd ? rb : 4'hF;
    if (in_code inside {4'h3, 4'h6}) return rb;
    if (in_code inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] f_dst_m();
    if (in_code inside {4'h5, 4'hB}) return ra;
    return 4'hF;
  endfunction

  function automatic logic [63:0] f_rd(input logic [3:0] id);
    if (id == 4'hF) return 64'd0;
    return m_regs[id];
  endfunction

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // Reference model update on the clock edge.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) m_regs[i] <= 64'd0;
      m_stat <= 2'd0;
      m_ret  <= '0;
    end else if (m_stat == 2'd0) begin
      if (bad_mem || dmem_error) m_stat <= 2'd2;
      else if (in_error)         m_stat <= 2'd3;
      else if (flag_halt)        m_stat <= 2'd1;
      else begin
        if (f_dst_e() != 4'hF) m_regs[f_dst_e()] <= val_e;
        if (f_dst_m() != 4'hF) m_regs[f_dst_m()] <= val_m;
        if (m_ret != {CW{1'b1}}) m_ret <= m_ret + 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("val_a", val_a, f_rd(f_src_a()));
      chk("val_b", val_b, f_rd(f_src_b()));
      chk("dst_e", 64'(dst_e), 64'(f_dst_e()));
      chk("dst_m", 64'(dst_m), 64'(f_dst_m()));
      chk("stat", 64'(stat), 64'(m_stat));
      chk("retired", 64'(retired), 64'(m_ret));
      chk("dbg_val", dbg_val, f_rd(dbg_sel));
    end
  end

  task automatic drive(input logic [3:0] c, input logic [3:0] a,
                       input logic [3:0] b, input logic [63:0] e,
                       input logic [63:0] m);
    in_code = c; ra = a; rb = b; val_e = e; val_m = m;
    flag_halt = 0; bad_mem = 0; in_error = 0; dmem_error = 0;
    cnd = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic peek(input logic [3:0] s, input logic [63:0] e,
                      input string n);
    dbg_sel = s;
    #1;
    chk(n, dbg_val, e);
  endtask

  task automatic irmov(input logic [3:0] r, input logic [63:0] v);
    drive(4'h3, 4'hF, r, v, 64'd0);
    tick();
  endtask

  initial begin
    drive(4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
    in_fun = 4'd0; dbg_sel = 4'd0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_stat", 64'(stat), 64'd0);
    chk("rst_ret", 64'(retired), 64'd0);
    peek(4'd2, 64'd0, "rst_r2");

    drive(4'h3, 4'hF, 4'd2, 64'h1234, 64'd0);
    #1 chk("irmov_dste", 64'(dst_e), 64'd2);
    tick();
    peek(4'd2, 64'h1234, "irmov_r2");
    chk("irmov_ret", 64'(retired), 64'd1);
    chk("irmov_stat", 64'(stat), 64'd0);

    irmov(4'd2, 64'd5);
    irmov(4'd3, 64'd7);
    drive(4'h6, 4'd2, 4'd3, 64'd12, 64'd0);
    #1 chk("opq_vala", val_a, 64'd5);
    chk("opq_valb", val_b, 64'd7);
    tick();
    peek(4'd3, 64'd12, "opq_r3");

    irmov(4'd4, 64'h100);
    drive(4'hB, 4'd4, 4'hF, 64'h108, 64'hABCD);
    #1 chk("pop_vala", val_a, 64'h100);
    chk("pop_valb", val_b, 64'h100);
    tick();
    peek(4'd4, 64'hABCD, "pop_r4");

    drive(4'h2, 4'd1, 4'd5, 64'd9, 64'd0);
    #1 chk("cmov0_dste", 64'(dst_e), 64'hF);
    tick();
    peek(4'd5, 64'd0, "cmov0_r5");
    chk("cmov0_ret", 64'(retired), 64'd7);
    drive(4'h2, 4'd1, 4'd5, 64'd9, 64'd0);
    cnd = 1'b1;
    tick();
    peek(4'd5, 64'd9, "cmov1_r5");
    chk("cmov1_ret", 64'(retired), 64'd8);
    peek(4'hF, 64'd0, "dbg_none");

    drive(4'h3, 4'hF, 4'd6, 64'd77, 64'd0);
    flag_halt = 1'b1;
    tick();
    chk("halt_stat", 64'(stat), 64'd1);
    peek(4'd6, 64'd0, "halt_r6");
    irmov(4'd7, 64'd55);
    peek(4'd7, 64'd0, "halt_r7");
    chk("halt_ret", 64'(retired), 64'd8);

    drive(4'h3, 4'hF, 4'd2, 64'd99, 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    peek(4'd2, 64'd0, "rst2_r2");
    peek(4'd3, 64'd0, "rst2_r3");
    chk("rst2_stat", 64'(stat), 64'd0);
    chk("rst2_ret", 64'(retired), 64'd0);

    drive(4'h3, 4'hF, 4'd1, 64'd3, 64'd0);
    bad_mem = 1'b1; in_error = 1'b1;
    tick();
    chk("adr_stat", 64'(stat), 64'd2);
    peek(4'd1, 64'd0, "adr_r1");

    reset = 1'b1; tick(); reset = 1'b0;
    drive(4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
    in_error = 1'b1;
    tick();
    chk("ins_stat", 64'(stat), 64'd3);

    reset = 1'b1; tick(); reset = 1'b0;
    drive(4'h5, 4'd8, 4'd2, 64'd0, 64'd44);
    dmem_error = 1'b1;
    tick();
    chk("dmem_stat", 64'(stat), 64'd2);
    peek(4'd8, 64'd0, "dmem_r8");

    reset = 1'b1; tick(); reset = 1'b0;
    drive(4'hC, 4'd1, 4'd1, 64'd66, 64'd66);
    tick();
    peek(4'd1, 64'd0, "unk_r1");
    chk("unk_ret", 64'(retired), 64'd1);
    drive(4'h5, 4'd9, 4'd1, 64'd0, 64'h5A);
    tick();
    peek(4'd9, 64'h5A, "mrmov_r9");
    drive(4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_ret", 64'(retired), 64'hF);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_wb_seq.md
Name: decode_wb_seq

Overview:
- Decode and write-back stage of the SEQ Y86-64 core, directly downstream of fetch_seq.
- Consumes fetch's in_code, in_fun, ra, rb and status flags.
- Holds the 15-entry register file and produces val_a/val_b for execute.
- Commits val_e/val_m at the clock edge and keeps the sticky processor status plus a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter (saturating).
- RSP_ID, 4, register ID of %rsp.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_code  input  4  icode from fetch.
- in_fun  input  4  ifun from fetch (unused by decode; passed for completeness).
- ra  input  4  rA field from fetch.
- rb  input  4  rB field from fetch.
- flag_halt  input  1  fetch decoded halt.
- bad_mem  input  1  fetch address error.
- in_error  input  1  fetch invalid instruction.
- dmem_error  input  1  data-memory error for the current instruction.
- cnd  input  1  condition result from execute (used for cmovXX).
- val_e  input  64  ALU result.
- val_m  input  64  memory read data.
- dbg_sel  input  4  debug register select.
- val_a  output  64  srcA read data.
- val_b  output  64  srcB read data.
- dst_e  output  4  E-port destination (F = none).
- dst_m  output  4  M-port destination (F = none).
- stat  output  2  0 = AOK, 1 = HLT, 2 = ADR, 3 = INS.
- retired  output  CNT_W  count of committed instructions.
- dbg_val  output  64  register dbg_sel (0 when dbg_sel = F).

Behaviour:
- srcA:
  - ra for icode 2, 4, 6, A.
  - RSP_ID for icode 9, B.
  - F otherwise.
- srcB:
  - rb for icode 4, 5, 6.
  - RSP_ID for icode 8, 9, A, B.
  - F otherwise.
- dst_e:
  - icode 2: rb if cnd, else F.
  - icode 3, 6: rb.
  - icode 8, 9, A, B: RSP_ID.
  - else F.
- dst_m: ra for icode 5, B; else F.
- val_a/val_b/dbg_val are combinational reads. ID F reads 0.
- A read of a register being written this cycle returns the pre-edge value.
- Commit condition, evaluated at posedge:
  - stat == AOK, and
  - none of flag_halt, bad_mem, in_error, dmem_error asserted.
- On commit:
  - Write val_e to dst_e if dst_e != F.
  - Write val_m to dst_m if dst_m != F.
  - If dst_e == dst_m (popq %rsp), val_m wins.
- Retired counter:
  - Increments by 1 on each commit, including nop and halt-free no-write instructions.
  - Saturates at all-ones; never wraps.
- Status update:
  - While stat == AOK, at posedge priority is: bad_mem or dmem_error -> ADR; else in_error -> INS; else flag_halt -> HLT; else stays AOK.
  - The error-causing instruction performs no register write and is not counted.
- Sticky status: once stat != AOK, it holds and all writes and counting are blocked until reset.
- Reset (synchronous, active-high):
  - All 15 registers cleared to 0, stat = AOK, retired = 0.
  - Reset dominates any same-cycle write.
  - Reset mid-operation discards the in-flight commit.
- Outputs reset values:
  - val_a/val_b/dbg_val reflect zeroed registers.
  - dst_e/dst_m are purely combinational from inputs.
- Unknown icode (C–F) with in_error low: no writes. Status is driven by in_error from fetch, not decoded here.

Test Plan:
- Reset, then irmovq (icode 3, rb = 2, val_e = 64'h1234) for one edge -> R2 = 64'h1234, retired = 1, stat = 0, dst_e = 2.
- OPq (icode 6, ra = 2, rb = 3) with R2 = 5, R3 = 7 -> val_a = 5, val_b = 7. After edge with val_e = 12, R3 = 12.
- popq %rsp (icode B, ra = 4), val_e = 64'h108, val_m = 64'hABCD -> after edge R4 = 64'hABCD. Same cycle, val_a = val_b = old R4.
- cmov (icode 2, ra = 1, rb = 5, val_e = 9):
  - cnd = 0 -> dst_e = F, R5 unchanged, retired still increments.
  - cnd = 1 -> R5 = 9.
- flag_halt asserted with val_e = 77, dst_e pointing at R6 -> stat = 1, R6 unchanged, retired frozen. Later irmovq cycles do no writes until reset.
- bad_mem and in_error asserted together -> stat = 2 (ADR priority). Assert reset in the same cycle as a pending irmovq -> all registers 0, stat = 0, retired = 0.
